// File: rtl/mem_map_pkg.sv
// rtl/mem_map_pkg.sv - memory map offsets, TCON bit indices and device select type
package mem_map_pkg;

    localparam logic [31:0] OFF_TH      = 32'h0000_0000;
    localparam logic [31:0] OFF_TL      = 32'h0000_0004;
    localparam logic [31:0] OFF_TCON    = 32'h0000_0008;
    localparam logic [31:0] OFF_LED     = 32'h0000_000C;
    localparam logic [31:0] OFF_DIGI    = 32'h0000_0010;
    localparam logic [31:0] OFF_SYSTICK = 32'h0000_0014;

    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_IF = 2;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_TH,
        SEL_TL,
        SEL_TCON,
        SEL_LED,
        SEL_DIGI,
        SEL_SYSTICK
    } dev_sel_t;

endpackage

// File: rtl/mem_bus_system_if.sv
// rtl/mem_bus_system_if.sv - CPU MEM-stage data bus (strobes, address, data)
interface mem_bus_system_if;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] MemBus_Address;
    logic [31:0] MemBus_Write_Data;
    logic [31:0] Device_Read_Data;

    modport master (
        output MemRead, MemWrite, MemBus_Address, MemBus_Write_Data,
        input  Device_Read_Data
    );

    modport slave (
        input  MemRead, MemWrite, MemBus_Address, MemBus_Write_Data,
        output Device_Read_Data
    );
endinterface

// File: rtl/mmio_timer.sv
// rtl/mmio_timer.sv - TH/TL/TCON reload timer; interrupt flag and irq under TIMER_IRQ_EN
module mmio_timer
    import mem_map_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_th,
    input  logic        wr_tl,
    input  logic        wr_tcon,
    input  logic [31:0] wdata,
    output logic [31:0] th,
    output logic [31:0] tl,
    output logic [2:0]  tcon
`ifdef TIMER_IRQ_EN
    ,
    output logic        irq
`endif
);

    logic overflow;
    assign overflow = tcon[TCON_EN] && (tl == 32'hFFFF_FFFF);

    // reload value register, software-written only
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     th <= '0;
        else if (wr_th) th <= wdata;
    end

    // counter: a CPU write beats count/reload; reload takes the pre-edge TH
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                tl <= '0;
        else if (wr_tl)            tl <= wdata;
        else if (tcon[TCON_EN])    tl <= overflow ? th : tl + 32'd1;
    end

`ifdef TIMER_IRQ_EN
    logic       if_set;
    logic [2:0] tcon_next;
    assign if_set = overflow && tcon[TCON_IE];

    // next TCON: an overflow sets IF even when software clears it that cycle
    always_comb begin
        tcon_next = tcon;
        if (wr_tcon) tcon_next = {wdata[2] | if_set, wdata[1:0]};
        else         tcon_next[TCON_IF] = tcon[TCON_IF] | if_set;
    end

    // control register and registered interrupt output
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcon <= '0;
            irq  <= 1'b0;
        end else begin
            tcon <= tcon_next;
            irq  <= tcon_next[TCON_IE] & tcon_next[TCON_IF];
        end
    end
`else
    logic en;

    // only the enable bit exists; IE/IF read as zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       en <= 1'b0;
        else if (wr_tcon) en <= wdata[TCON_EN];
    end

    assign tcon = {2'b00, en};
`endif

endmodule

// File: rtl/mem_bus_system.sv
// rtl/mem_bus_system.sv - zero-wait data bus: RAM + MMIO timer/LED/DIGI/SYSTICK; option TIMER_IRQ_EN
module mem_bus_system
    import mem_map_pkg::*;
#(
    parameter int          DM_WORDS    = 256,
    parameter logic [31:0] PERIPH_BASE = 32'h4000_0000,
    parameter int          LED_W       = 8
) (
    input  logic               clk,
    input  logic               reset,
    mem_bus_system_if.slave    bus,
    output logic [LED_W-1:0]   leds,
    output logic [11:0]        digi,
    output logic               bus_err
`ifdef TIMER_IRQ_EN
    ,
    output logic               irq
`endif
);

    localparam int AW = $clog2(DM_WORDS);

    logic [31:0]   mem [DM_WORDS];
    logic [31:0]   addr;
    logic [31:0]   off;
    logic [AW-1:0] ram_idx;
    logic [31:0]   systick;
    logic [31:0]   th, tl;
    logic [2:0]    tcon;
    dev_sel_t      sel;
    logic          wr;

    assign addr    = bus.MemBus_Address & ~32'h3;
    assign off     = addr - PERIPH_BASE;
    assign ram_idx = addr[AW+1:2];
    assign wr      = bus.MemWrite;

    // address decoder
    always_comb begin
        sel = SEL_NONE;
        if (addr[31:AW+2] == '0) begin
            sel = SEL_RAM;
        end else begin
            case (off)
                OFF_TH:      sel = SEL_TH;
                OFF_TL:      sel = SEL_TL;
                OFF_TCON:    sel = SEL_TCON;
                OFF_LED:     sel = SEL_LED;
                OFF_DIGI:    sel = SEL_DIGI;
                OFF_SYSTICK: sel = SEL_SYSTICK;
                default:     sel = SEL_NONE;
            endcase
        end
    end

    // data RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (wr && sel == SEL_RAM) mem[ram_idx] <= bus.MemBus_Write_Data;
    end

    // LED, DIGI, free-running SYSTICK and sticky bus error
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            leds    <= '0;
            digi    <= '0;
            systick <= '0;
            bus_err <= 1'b0;
        end else begin
            systick <= systick + 32'd1;
            if (wr && sel == SEL_LED)  leds <= bus.MemBus_Write_Data[LED_W-1:0];
            if (wr && sel == SEL_DIGI) digi <= bus.MemBus_Write_Data[11:0];
            if ((bus.MemRead || bus.MemWrite) && sel == SEL_NONE) bus_err <= 1'b1;
        end
    end

    mmio_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .wr_th   (wr && sel == SEL_TH),
        .wr_tl   (wr && sel == SEL_TL),
        .wr_tcon (wr && sel == SEL_TCON),
        .wdata   (bus.MemBus_Write_Data),
        .th      (th),
        .tl      (tl),
        .tcon    (tcon)
`ifdef TIMER_IRQ_EN
        ,
        .irq     (irq)
`endif
    );

    // combinational read mux; pre-edge values, zero when idle or unmapped
    always_comb begin
        bus.Device_Read_Data = '0;
        if (bus.MemRead) begin
            case (sel)
                SEL_RAM:     bus.Device_Read_Data = mem[ram_idx];
                SEL_TH:      bus.Device_Read_Data = th;
                SEL_TL:      bus.Device_Read_Data = tl;
                SEL_TCON:    bus.Device_Read_Data = 32'(tcon);
                SEL_LED:     bus.Device_Read_Data = 32'(leds);
                SEL_DIGI:    bus.Device_Read_Data = 32'(digi);
                SEL_SYSTICK: bus.Device_Read_Data = systick;
                default:     bus.Device_Read_Data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_system.sv
// tb/tb_mem_bus_system.sv - directed self-checking bench for mem_bus_system
module tb_mem_bus_system;

    localparam logic [31:0] B = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  leds;
    logic [11:0] digi;
    logic        bus_err;
`ifdef TIMER_IRQ_EN
    logic        irq;
    localparam logic [31:0] TC3 = 32'h3;
    localparam logic [31:0] TC7 = 32'h7;
`else
    localparam logic [31:0] TC3 = 32'h1;
    localparam logic [31:0] TC7 = 32'h1;
`endif

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] d;
    logic [31:0] tick_model = '0;

    mem_bus_system_if bus_if ();

    mem_bus_system dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus_if),
        .leds    (leds),
        .digi    (digi),
        .bus_err (bus_err)
`ifdef TIMER_IRQ_EN
        ,
        .irq     (irq)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) tick_model <= reset ? tick_model + 32'd1 : 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] v);
        bus_if.MemRead           = 1'b0;
        bus_if.MemWrite          = 1'b1;
        bus_if.MemBus_Address    = a;
        bus_if.MemBus_Write_Data = v;
        tick();
        bus_if.MemWrite          = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        bus_if.MemWrite       = 1'b0;
        bus_if.MemRead        = 1'b1;
        bus_if.MemBus_Address = a;
        #1;
        v = bus_if.Device_Read_Data;
        bus_if.MemRead        = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        bus_if.MemRead = 1'b0;
        bus_if.MemWrite = 1'b0;
        bus_if.MemBus_Address = '0;
        bus_if.MemBus_Write_Data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_leds", 32'(leds), 32'h0);
        chk("rst_digi", 32'(digi), 32'h0);
        chk("rst_bus_err", 32'(bus_err), 32'h0);
        chk("rst_rdata_idle", bus_if.Device_Read_Data, 32'h0);
        rd(B + 32'h14, d); chk("rst_systick", d, 32'h0);
`ifdef TIMER_IRQ_EN
        chk("rst_irq", 32'(irq), 32'h0);
`endif
        reset = 1'b1;
        tick();

        // RAM write then reads, byte offset ignored, idle read is zero
        wr(32'h10, 32'h1234_5678);
        rd(32'h10, d); chk("ram_rd_10", d, 32'h1234_5678);
        rd(32'h13, d); chk("ram_rd_13", d, 32'h1234_5678);
        bus_if.MemBus_Address = 32'h10; #1;
        chk("ram_noread_zero", bus_if.Device_Read_Data, 32'h0);
        wr(32'h3FC, 32'hCAFE_F00D);
        rd(32'h3FC, d); chk("ram_last_word", d, 32'hCAFE_F00D);

        // timer count and reload from TH
        wr(B + 32'h0, 32'hFFFF_FFFC);
        wr(B + 32'h4, 32'hFFFF_FFFE);
        wr(B + 32'h8, 32'h3);
        rd(B + 32'h4, d); chk("tl_after_en", d, 32'hFFFF_FFFE);
        tick();
        rd(B + 32'h4, d); chk("tl_max", d, 32'hFFFF_FFFF);
`ifdef TIMER_IRQ_EN
        chk("irq_before_reload", 32'(irq), 32'h0);
`endif
        tick();
        rd(B + 32'h4, d); chk("tl_reload", d, 32'hFFFF_FFFC);
        rd(B + 32'h8, d); chk("tcon_after_ovf", d, TC7);
`ifdef TIMER_IRQ_EN
        chk("irq_after_reload", 32'(irq), 32'h1);
`endif
        tick();
        rd(B + 32'h4, d); chk("tl_after_reload", d, 32'hFFFF_FFFD);
        rd(B + 32'h0, d); chk("th_read", d, 32'hFFFF_FFFC);

        // TCON write coinciding with overflow keeps IF
        wr(B + 32'h8, 32'h3);
        rd(B + 32'h8, d); chk("tcon_clear_if", d, TC3);
        wr(B + 32'h4, 32'hFFFF_FFFF);
        rd(B + 32'h4, d); chk("tl_write", d, 32'hFFFF_FFFF);
        wr(B + 32'h8, 32'h3);
        rd(B + 32'h8, d); chk("tcon_ovf_wins", d, TC7);
        rd(B + 32'h4, d); chk("tl_reload2", d, 32'hFFFF_FFFC);
        wr(B + 32'h8, 32'h3);
        rd(B + 32'h8, d); chk("tcon_sw_clear", d, TC3);
        rd(B + 32'h4, d); chk("tl_count2", d, 32'hFFFF_FFFD);
`ifdef TIMER_IRQ_EN
        chk("irq_dropped", 32'(irq), 32'h0);
`endif
        wr(B + 32'h8, 32'h0);
        tick();
        rd(B + 32'h4, d); chk("tl_hold", d, 32'hFFFF_FFFE);

        // unmapped access and read-only SYSTICK
        bus_if.MemRead = 1'b1;
        bus_if.MemBus_Address = 32'h5000_0000;
        #1;
        chk("unmapped_rdata", bus_if.Device_Read_Data, 32'h0);
        chk("bus_err_pre_edge", 32'(bus_err), 32'h0);
        tick();
        chk("bus_err_set", 32'(bus_err), 32'h1);
        bus_if.MemRead = 1'b0;
        tick();
        chk("bus_err_sticky", 32'(bus_err), 32'h1);
        rd(B + 32'h18, d); chk("unmapped_mmio", d, 32'h0);
        rd(B + 32'h14, d); chk("systick_a", d, tick_model);
        wr(B + 32'h14, 32'h0);
        rd(B + 32'h14, d); chk("systick_wr_ignored", d, tick_model);
        tick();
        rd(B + 32'h14, d); chk("systick_b", d, tick_model);

        // simultaneous read and write returns the pre-edge value
        wr(B + 32'hC, 32'h3C);
        bus_if.MemRead = 1'b1;
        bus_if.MemWrite = 1'b1;
        bus_if.MemBus_Address = B + 32'hC;
        bus_if.MemBus_Write_Data = 32'hFFFF_FFA5;
        #1;
        chk("led_old_rd", bus_if.Device_Read_Data, 32'h3C);
        tick();
        bus_if.MemWrite = 1'b0;
        bus_if.MemRead = 1'b0;
        chk("leds_port", 32'(leds), 32'hA5);
        rd(B + 32'hC, d); chk("led_zero_ext", d, 32'hA5);
        bus_if.MemRead = 1'b1;
        bus_if.MemWrite = 1'b1;
        bus_if.MemBus_Address = B + 32'h10;
        bus_if.MemBus_Write_Data = 32'h1FF;
        #1;
        chk("digi_old_rd", bus_if.Device_Read_Data, 32'h0);
        tick();
        bus_if.MemWrite = 1'b0;
        bus_if.MemRead = 1'b0;
        chk("digi_port", 32'(digi), 32'h1FF);
        rd(B + 32'h10, d); chk("digi_rd", d, 32'h1FF);

        // asynchronous reset mid-count
        wr(B + 32'h4, 32'h10);
        wr(B + 32'h8, 32'h3);
        tick();
        reset = 1'b0;
        #1;
        rd(B + 32'h4, d);  chk("arst_tl", d, 32'h0);
        rd(B + 32'h8, d);  chk("arst_tcon", d, 32'h0);
        rd(B + 32'hC, d);  chk("arst_led", d, 32'h0);
        rd(B + 32'h14, d); chk("arst_systick", d, 32'h0);
        chk("arst_leds_port", 32'(leds), 32'h0);
        chk("arst_digi_port", 32'(digi), 32'h0);
        chk("arst_bus_err", 32'(bus_err), 32'h0);
`ifdef TIMER_IRQ_EN
        chk("arst_irq", 32'(irq), 32'h0);
`endif
        tick();
        reset = 1'b1;
        tick();
        rd(B + 32'h14, d); chk("systick_restart", d, tick_model);
        rd(32'h10, d); chk("ram_kept", d, 32'h1234_5678);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
